// File: rtl/morse_collector_pkg.sv
// Shared Morse receiver definitions: symbol encoding, letter widths and
// the collector state encoding, also imported by the downstream decoder.
package morse_pkg;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int MAX_SYMBOLS = 5;
    localparam int CODE_W      = 5;
    localparam int DIGIT_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Place a symbol MSB-first: the first symbol lands in the top bit.
    function automatic logic [CODE_W-1:0] sr_insert(
        input logic [CODE_W-1:0]  sr,
        input logic [DIGIT_W-1:0] cnt,
        input logic               sym
    );
        logic [CODE_W-1:0] r;
        logic [2:0]        idx;
        r      = sr;
        idx    = 3'(CODE_W - 1) - cnt;
        r[idx] = sym;
        return r;
    endfunction

endpackage

// File: rtl/morse_collector_if.sv
// Key/abort inputs and completed-letter outputs of the Morse collector.
interface morse_collector_if;
    import morse_pkg::*;

    logic               key;
    logic               clr;
    logic [CODE_W-1:0]  code;
    logic [DIGIT_W-1:0] digit;
    logic               valid;
    logic               overflow;
    logic               busy;

    modport master (
        output key, clr,
        input  code, digit, valid, overflow, busy
    );

    modport slave (
        input  key, clr,
        output code, digit, valid, overflow, busy
    );

endinterface

// File: rtl/morse_collector_debounce.sv
// Two-flop synchroniser followed by a DEB_TICKS stability filter; emits the
// debounced level plus one-cycle rise/fall pulses aligned with its change.
module key_debounce #(
    parameter int DEB_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic kd_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(DEB_TICKS + 1);

    logic          sync1_q, sync2_q;
    logic          kd_q, kd_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Stability counter: any return to the current level restarts it.
    always_comb begin
        kd_d   = kd_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        cnt_d  = '0;
        if (sync2_q != kd_q) begin
            if (cnt_q == CW'(DEB_TICKS - 1)) begin
                kd_d   = sync2_q;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser and filter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            kd_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            kd_q    <= kd_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign kd_o   = kd_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/morse_collector.sv
// Times debounced key presses into dots/dashes, collects up to five symbols
// and closes the letter after an idle gap with a one-cycle valid strobe.
module morse_collector
    import morse_pkg::*;
#(
    parameter int DEB_TICKS  = 4,
    parameter int DASH_TICKS = 20,
    parameter int GAP_TICKS  = 40
) (
    input  logic              clk,
    input  logic              rst,
    morse_collector_if.slave  bus
);

    localparam int PW = $clog2(DASH_TICKS + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);

    logic kd_s, rise_s, fall_s;

    state_e             state_q, state_d;
    logic [PW-1:0]      press_q, press_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [CODE_W-1:0]  sr_q, sr_d;
    logic [DIGIT_W-1:0] cnt_q, cnt_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               close_s, ovf_s, sym_s;

    key_debounce #(.DEB_TICKS(DEB_TICKS)) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .key_i  (bus.key),
        .kd_o   (kd_s),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    // State register, including counters and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            press_q    <= '0;
            gap_q      <= '0;
            sr_q       <= '0;
            cnt_q      <= '0;
            code_q     <= '0;
            digit_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            press_q    <= press_d;
            gap_q      <= gap_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; the close fires on the cycle the gap count hits GAP_TICKS.
    always_comb begin
        state_d = state_q;
        press_d = press_q;
        gap_d   = gap_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        close_s = 1'b0;
        ovf_s   = 1'b0;
        sym_s   = (press_q >= PW'(DASH_TICKS)) ? SYM_DASH : SYM_DOT;
        if (bus.clr) begin
            state_d = IDLE;
            press_d = '0;
            gap_d   = '0;
            sr_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    sr_d  = '0;
                    cnt_d = '0;
                    gap_d = '0;
                    if (rise_s) begin
                        state_d = PRESS;
                        press_d = PW'(1);
                    end else begin
                        press_d = '0;
                    end
                end
                PRESS: begin
                    if (fall_s) begin
                        gap_d   = '0;
                        press_d = '0;
                        if (cnt_q < DIGIT_W'(MAX_SYMBOLS)) begin
                            sr_d    = sr_insert(sr_q, cnt_q, sym_s);
                            cnt_d   = cnt_q + DIGIT_W'(1);
                            state_d = GAP;
                        end else begin
                            ovf_s   = 1'b1;
                            sr_d    = '0;
                            cnt_d   = '0;
                            state_d = DRAIN;
                        end
                    end else if (kd_s && (press_q < PW'(DASH_TICKS))) begin
                        press_d = press_q + PW'(1);
                    end else begin
                        press_d = press_q;
                    end
                end
                GAP: begin
                    if (rise_s) begin
                        state_d = PRESS;
                        press_d = PW'(1);
                        gap_d   = '0;
                    end else if (!kd_s) begin
                        if (gap_q == GW'(GAP_TICKS - 1)) begin
                            close_s = 1'b1;
                            sr_d    = '0;
                            cnt_d   = '0;
                            gap_d   = '0;
                            state_d = IDLE;
                        end else begin
                            gap_d = gap_q + GW'(1);
                        end
                    end else begin
                        gap_d = gap_q;
                    end
                end
                DRAIN: begin
                    if (kd_s) begin
                        gap_d = '0;
                    end else if (gap_q == GW'(GAP_TICKS - 1)) begin
                        gap_d   = '0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    press_d = '0;
                    gap_d   = '0;
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic: strobes and the held letter registers.
    always_comb begin
        valid_d    = close_s;
        overflow_d = ovf_s;
        busy_d     = (state_d != IDLE);
        if (close_s) begin
            code_d  = sr_q;
            digit_d = cnt_q;
        end else begin
            code_d  = code_q;
            digit_d = digit_q;
        end
    end

    assign bus.code     = code_q;
    assign bus.digit    = digit_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_morse_collector.sv
// Directed bench for morse_collector with DEB=4, DASH=20, GAP=40.
module tb_morse_collector;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    int         v_cnt;
    int         v_at;
    int         o_cnt;
    int         both_cnt;
    logic       busy_seen;
    logic [4:0] v_code;
    logic [2:0] v_digit;

    morse_collector_if bus ();

    morse_collector #(
        .DEB_TICKS  (4),
        .DASH_TICKS (20),
        .GAP_TICKS  (40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_mon();
        v_cnt     = 0;
        v_at      = -1;
        o_cnt     = 0;
        both_cnt  = 0;
        busy_seen = 1'b0;
        v_code    = 5'd0;
        v_digit   = 3'd0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) begin
                if (v_at < 0) v_at = i + 1;
                v_cnt   = v_cnt + 1;
                v_code  = bus.code;
                v_digit = bus.digit;
            end
            if (bus.overflow === 1'b1) o_cnt = o_cnt + 1;
            if (bus.valid === 1'b1 && bus.overflow === 1'b1) both_cnt = both_cnt + 1;
            if (bus.busy === 1'b1) busy_seen = 1'b1;
        end
    endtask

    task automatic press(input int n);
        bus.key = 1'b1;
        run(n);
        bus.key = 1'b0;
    endtask

    task automatic check_letter(input string name, input logic [4:0] ecode, input logic [2:0] edigit);
        tests = tests + 1;
        if (v_cnt !== 1) begin
            $display("FAIL %s valid_count got %0d want 1", name, v_cnt); fails = fails + 1;
        end
        tests = tests + 1;
        if (v_code !== ecode || v_digit !== edigit) begin
            $display("FAIL %s letter got code=%b digit=%0d want code=%b digit=%0d",
                     name, v_code, v_digit, ecode, edigit);
            fails = fails + 1;
        end
        tests = tests + 1;
        if (o_cnt !== 0 || bus.busy !== 1'b0) begin
            $display("FAIL %s end_state got ovf=%0d busy=%b want ovf=0 busy=0", name, o_cnt, bus.busy);
            fails = fails + 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.key = 1'b0; bus.clr = 1'b0;
        run(3);
        rst = 1'b0;
        run(1);
        tests = tests + 1;
        if (bus.code !== 5'd0 || bus.digit !== 3'd0 || bus.valid !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL reset got code=%b digit=%0d valid=%b ovf=%b busy=%b want all 0",
                     bus.code, bus.digit, bus.valid, bus.overflow, bus.busy);
            fails = fails + 1;
        end
    endtask

    task automatic test_single_dot();
        clear_mon();
        press(10);
        tests = tests + 1;
        if (bus.busy !== 1'b1) begin
            $display("FAIL dot_busy got %b want 1", bus.busy); fails = fails + 1;
        end
        clear_mon();
        run(60);
        check_letter("single_dot", 5'b00000, 3'd1);
        tests = tests + 1;
        if (v_at !== 47) begin
            $display("FAIL dot_latency got %0d want 47", v_at); fails = fails + 1;
        end
    endtask

    task automatic test_letter_c();
        clear_mon();
        press(30); run(15);
        press(8);  run(15);
        press(30); run(15);
        press(8);  run(60);
        check_letter("letter_c", 5'b10100, 3'd4);
    endtask

    task automatic test_five_dashes();
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            press(25);
            run(15);
        end
        run(45);
        check_letter("five_dashes", 5'b11111, 3'd5);
    endtask

    task automatic test_overflow();
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            press(25);
            if (i < 5) run(15);
        end
        run(20);
        tests = tests + 1;
        if (o_cnt !== 1 || bus.busy !== 1'b1) begin
            $display("FAIL overflow_drain got ovf=%0d busy=%b want ovf=1 busy=1", o_cnt, bus.busy);
            fails = fails + 1;
        end
        run(40);
        tests = tests + 1;
        if (v_cnt !== 0 || o_cnt !== 1 || bus.busy !== 1'b0 || both_cnt !== 0) begin
            $display("FAIL overflow_end got valid=%0d ovf=%0d busy=%b both=%0d want 0 1 0 0",
                     v_cnt, o_cnt, bus.busy, both_cnt);
            fails = fails + 1;
        end
        tests = tests + 1;
        if (bus.code !== 5'b11111 || bus.digit !== 3'd5) begin
            $display("FAIL overflow_hold got code=%b digit=%0d want 11111 5", bus.code, bus.digit);
            fails = fails + 1;
        end
    endtask

    task automatic test_boundaries();
        clear_mon();
        press(20); run(60);
        check_letter("dash_20", 5'b10000, 3'd1);
        clear_mon();
        press(19); run(60);
        check_letter("dot_19", 5'b00000, 3'd1);
        clear_mon();
        press(8); run(39);
        press(25); run(60);
        check_letter("gap_39", 5'b01000, 3'd2);
    endtask

    task automatic test_bounce();
        clear_mon();
        bus.key = 1'b1;
        run(3);
        bus.key = 1'b0;
        run(30);
        tests = tests + 1;
        if (busy_seen !== 1'b0 || v_cnt !== 0 || o_cnt !== 0) begin
            $display("FAIL bounce got busy_seen=%b valid=%0d ovf=%0d want 0 0 0", busy_seen, v_cnt, o_cnt);
            fails = fails + 1;
        end
    endtask

    task automatic test_clr();
        clear_mon();
        press(25); run(15);
        press(8);  run(15);
        bus.clr = 1'b1;
        run(1);
        bus.clr = 1'b0;
        tests = tests + 1;
        if (bus.busy !== 1'b0) begin
            $display("FAIL clr_busy got %b want 0", bus.busy); fails = fails + 1;
        end
        run(60);
        tests = tests + 1;
        if (v_cnt !== 0 || o_cnt !== 0 || bus.code !== 5'b01000 || bus.digit !== 3'd2) begin
            $display("FAIL clr_hold got valid=%0d ovf=%0d code=%b digit=%0d want 0 0 01000 2",
                     v_cnt, o_cnt, bus.code, bus.digit);
            fails = fails + 1;
        end
    endtask

    task automatic test_rst_mid_press();
        clear_mon();
        bus.key = 1'b1;
        run(12);
        rst = 1'b1;
        run(1);
        tests = tests + 1;
        if (bus.code !== 5'd0 || bus.digit !== 3'd0 || bus.valid !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL rst_mid_press got code=%b digit=%0d valid=%b ovf=%b busy=%b want all 0",
                     bus.code, bus.digit, bus.valid, bus.overflow, bus.busy);
            fails = fails + 1;
        end
        bus.key = 1'b0;
        run(3);
        rst = 1'b0;
        clear_mon();
        run(60);
        tests = tests + 1;
        if (v_cnt !== 0 || busy_seen !== 1'b0) begin
            $display("FAIL rst_after got valid=%0d busy_seen=%b want 0 0", v_cnt, busy_seen);
            fails = fails + 1;
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        bus.key = 1'b0;
        bus.clr = 1'b0;
        clear_mon();
        test_reset();
        test_single_dot();
        test_letter_c();
        test_five_dashes();
        test_overflow();
        test_boundaries();
        test_bounce();
        test_clr();
        test_rst_mid_press();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
